// File: rtl/fpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_pkg : shared fdiv scheduler constants, sideband entry type, index width
// Revision: 1.0
// ----------------------------------------------------------------------------
package fpu_pkg;

  localparam int FDIV_LAT  = 4;
  localparam int FDIV_TAGW = 5;
  localparam int FDIV_IDW  = 2;

  typedef struct packed {
    logic                 v;
    logic [FDIV_IDW-1:0]  id;
    logic [FDIV_TAGW-1:0] tag;
  } fdiv_sb_t;

  // A single requester still needs a one-bit index field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_sched_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fdiv_sched_if : requester, fdiv and response signals of the fdiv scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
interface fdiv_sched_if #(
  parameter int NREQ = 2,
  parameter int LAT  = fpu_pkg::FDIV_LAT,
  parameter int TAGW = fpu_pkg::FDIV_TAGW
);

  localparam int CW = $clog2(LAT + 1);

  logic                   flush;
  logic [NREQ-1:0]        req_valid;
  logic [32*NREQ-1:0]     req_x1;
  logic [32*NREQ-1:0]     req_x2;
  logic [TAGW*NREQ-1:0]   req_tag;
  logic [NREQ-1:0]        req_ready;
  logic [31:0]            div_x1;
  logic [31:0]            div_x2;
  logic [31:0]            div_y;
  logic                   div_ovf;
  logic [NREQ-1:0]        rsp_valid;
  logic [31:0]            rsp_y;
  logic                   rsp_ovf;
  logic [TAGW-1:0]        rsp_tag;
  logic [CW-1:0]          inflight;
  logic                   busy;

  modport master (
    output flush, req_valid, req_x1, req_x2, req_tag, div_y, div_ovf,
    input  req_ready, div_x1, div_x2, rsp_valid, rsp_y, rsp_ovf, rsp_tag,
           inflight, busy
  );

  modport slave (
    input  flush, req_valid, req_x1, req_x2, req_tag, div_y, div_ovf,
    output req_ready, div_x1, div_x2, rsp_valid, rsp_y, rsp_ovf, rsp_tag,
           inflight, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb : NREQ-way round-robin arbiter, scan starts one past the pointer
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  wire  [NREQ-1:0] i_req,
  input  wire  [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fdiv_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fdiv_sched : shares one pipelined fdiv between NREQ requesters, routes results
// Revision: 1.0
// ----------------------------------------------------------------------------
module fdiv_sched
  import fpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = FDIV_LAT,
  parameter int TAGW = FDIV_TAGW
) (
  input wire          clk,
  input wire          rstn,
  fdiv_sched_if.slave bus
);

  localparam int IDW = idx_w(NREQ);
  localparam int CW  = $clog2(LAT + 1);

  typedef struct packed {
    logic            v;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
  } sb_t;

  logic [NREQ-1:0] w_arb_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_issue;
  logic            w_retire;
  logic [TAGW-1:0] w_tag;
  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   r_inflight;
  sb_t             r_pipe [LAT];
  sb_t             w_out;

  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_issue       = w_any & ~bus.flush;
  assign bus.req_ready = w_issue ? w_arb_grant : '0;
  assign w_tag         = bus.req_tag[TAGW*w_idx +: TAGW];

  // Idle cycles feed zeros; whatever the divider makes of them is never marked valid.
  always_comb begin
    bus.div_x1 = '0;
    bus.div_x2 = '0;
    if (w_issue) begin
      bus.div_x1 = bus.req_x1[32*w_idx +: 32];
      bus.div_x2 = bus.req_x2[32*w_idx +: 32];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (w_issue) begin
      r_ptr <= w_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < LAT; s++) begin
        r_pipe[s] <= '0;
      end
    end else begin
      r_pipe[0].v   <= w_issue;
      r_pipe[0].id  <= w_idx;
      r_pipe[0].tag <= w_tag;
      for (int s = 1; s < LAT; s++) begin
        r_pipe[s]   <= r_pipe[s-1];
        r_pipe[s].v <= r_pipe[s-1].v & ~bus.flush;
      end
    end
  end

  assign w_out    = r_pipe[LAT-1];
  assign w_retire = w_out.v;

  always_comb begin
    bus.rsp_valid = '0;
    if (w_out.v && !bus.flush) begin
      bus.rsp_valid = NREQ'(1) << w_out.id;
    end
  end

  assign bus.rsp_y   = bus.div_y;
  assign bus.rsp_ovf = bus.div_ovf;
  assign bus.rsp_tag = w_out.tag;

  // Tracks the number of set valid bits, so it is bounded by LAT by construction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= '0;
    end else if (bus.flush) begin
      r_inflight <= '0;
    end else if (w_issue && !w_retire) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (!w_issue && w_retire) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  assign bus.inflight = r_inflight;
  assign bus.busy     = (r_inflight != '0);

endmodule
`default_nettype wire

// File: tb/tb_fdiv_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fdiv_sched : scoreboard bench for fdiv_sched with a behavioural fdiv model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fdiv_sched;
  import fpu_pkg::*;

  localparam int NREQ = 2;
  localparam int LAT  = FDIV_LAT;
  localparam int TAGW = FDIV_TAGW;
  localparam int CW   = $clog2(LAT + 1);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fdiv_sched_if #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) bus ();

  fdiv_sched #(.NREQ(NREQ), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural divider: known quotients for the directed cases, x/0 overflows.
  function automatic logic [32:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return {1'b1, 32'h7F800000};
    if (a == 32'h40C00000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    if (a == 32'h3F800000 && b == 32'h40800000) return {1'b0, 32'h3E800000};
    return {1'b0, a ^ {b[15:0], b[31:16]}};
  endfunction

  logic [63:0] fd_hold;
  logic [63:0] fd_pipe [LAT];
  logic [32:0] fd_res;

  always @(negedge clk) fd_hold <= {bus.div_x1, bus.div_x2};
  always @(posedge clk) begin
    fd_pipe[0] <= fd_hold;
    for (int s = 1; s < LAT; s++) fd_pipe[s] <= fd_pipe[s-1];
  end
  assign fd_res      = fdiv_ref(fd_pipe[LAT-1][63:32], fd_pipe[LAT-1][31:0]);
  assign bus.div_y   = fd_res[31:0];
  assign bus.div_ovf = fd_res[32];

  // Reference model: an ordered list of accepted operations and their due cycles.
  typedef struct {
    int              due;
    int              id;
    logic [TAGW-1:0] tag;
    logic [31:0]     y;
    logic            ovf;
  } ent_t;

  ent_t         q[$];
  int           m_ptr;
  int           cyc = 0;
  int           exp_gid;
  logic [31:0]  exp_x1, exp_x2;
  logic [127:0] exp_vec;

  function automatic logic [NREQ-1:0] model_rr(input int ptr, input logic [NREQ-1:0] v);
    int i;
    for (int k = 1; k <= NREQ; k++) begin
      i = (ptr + k) % NREQ;
      if (v[i]) return NREQ'(1) << i;
    end
    return '0;
  endfunction

  task automatic model_expect();
    logic [NREQ-1:0] rdy, rv;
    logic [31:0]     y;
    logic [TAGW-1:0] tg;
    logic            ov;
    rdy = bus.flush ? '0 : model_rr(m_ptr, bus.req_valid);
    exp_gid = -1;
    for (int i = 0; i < NREQ; i++) if (rdy[i]) exp_gid = i;
    exp_x1 = '0;
    exp_x2 = '0;
    if (exp_gid >= 0) begin
      exp_x1 = bus.req_x1[32*exp_gid +: 32];
      exp_x2 = bus.req_x2[32*exp_gid +: 32];
    end
    rv = '0; y = '0; tg = '0; ov = 1'b0;
    if (q.size() > 0 && q[0].due == cyc && !bus.flush) begin
      rv[q[0].id] = 1'b1;
      y  = q[0].y;
      tg = q[0].tag;
      ov = q[0].ovf;
    end
    exp_vec = {rdy, rv, y, tg, ov, CW'(q.size()), q.size() != 0, exp_x1, exp_x2};
  endtask

  task automatic model_advance();
    ent_t        e;
    logic [32:0] r;
    if (bus.flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (exp_gid >= 0) begin
        r     = fdiv_ref(exp_x1, exp_x2);
        e.due = cyc + LAT;
        e.id  = exp_gid;
        e.tag = bus.req_tag[TAGW*exp_gid +: TAGW];
        e.y   = r[31:0];
        e.ovf = r[32];
        q.push_back(e);
        m_ptr = exp_gid;
      end
    end
    cyc++;
  endtask

  function automatic logic [127:0] obs_vec();
    logic v;
    v = |bus.rsp_valid;
    return {bus.req_ready, bus.rsp_valid, v ? bus.rsp_y : 32'h0,
            v ? bus.rsp_tag : {TAGW{1'b0}}, v ? bus.rsp_ovf : 1'b0,
            bus.inflight, bus.busy, bus.div_x1, bus.div_x2};
  endfunction

  task automatic idle();
    bus.req_valid = '0;
    bus.flush     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x1[32*i +: 32]     = $urandom;
      bus.req_x2[32*i +: 32]     = $urandom;
      bus.req_tag[TAGW*i +: TAGW] = TAGW'($urandom);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAGW-1:0] t);
    bus.req_valid[i]            = 1'b1;
    bus.req_x1[32*i +: 32]      = a;
    bus.req_x2[32*i +: 32]      = b;
    bus.req_tag[TAGW*i +: TAGW] = t;
  endtask

  task automatic sample();
    @(negedge clk);
    model_expect();
  endtask

  task automatic next();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    m_ptr = NREQ - 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    sample();
    if (obs_vec() !== exp_vec) begin errors++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
    checks++;
    if ({bus.rsp_valid, bus.inflight, bus.busy} !== '0) begin
      errors++; $display("FAIL reset_zero got rv=%b inf=%0d busy=%b exp 0", bus.rsp_valid, bus.inflight, bus.busy);
    end
    checks++;
    next();
    idle();
    bus.flush = 1'b1;
    set_req(0, $urandom, $urandom, 5'd1);
    set_req(1, $urandom, $urandom, 5'd2);
    sample();
    if (obs_vec() !== exp_vec) begin errors++; $display("FAIL reset_flush cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
    checks++;
    next();
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      if (k == 0) set_req(0, 32'h40C00000, 32'h40000000, 5'd3);
      sample();
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
      checks++;
      if (bus.busy) busy_cnt++;
      if (k == 4) begin
        if ({bus.rsp_valid, bus.rsp_y, bus.rsp_tag} !== {2'b01, 32'h40400000, 5'd3}) begin
          errors++; $display("FAIL single_rsp got rv=%b y=%h tag=%0d exp rv=01 y=40400000 tag=3", bus.rsp_valid, bus.rsp_y, bus.rsp_tag);
        end
        checks++;
      end
      next();
    end
    if (busy_cnt != 4) begin errors++; $display("FAIL single_busy got %0d cycles exp 4", busy_cnt); end
    checks++;
  endtask

  task automatic test_contention();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      idle();
      if (k < 4) begin
        set_req(0, $urandom, $urandom, TAGW'($urandom));
        set_req(1, $urandom, $urandom, TAGW'($urandom));
      end
      sample();
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL contention cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
      checks++;
      if (k < 4) begin
        if (bus.req_ready !== (2'b01 << (k % 2))) begin
          errors++; $display("FAIL contention_order k=%0d got=%b exp=%b", k, bus.req_ready, 2'b01 << (k % 2));
        end
        checks++;
      end
      next();
    end
  endtask

  task automatic test_back_to_back();
    int run = 0, best = 0, max_inf = 0;
    for (int k = 0; k < 14; k++) begin
      idle();
      if (k < 8) set_req(1, 32'h3F800000, 32'h40800000, TAGW'(k));
      sample();
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
      checks++;
      if (bus.rsp_valid === 2'b10 && bus.rsp_y === 32'h3E800000) run++;
      else run = 0;
      if (run > best) best = run;
      if (int'(bus.inflight) > max_inf) max_inf = int'(bus.inflight);
      next();
    end
    if (best != 8) begin errors++; $display("FAIL b2b_stream got %0d consecutive exp 8", best); end
    checks++;
    if (max_inf != 4) begin errors++; $display("FAIL b2b_inflight got max %0d exp 4", max_inf); end
    checks++;
  endtask

  task automatic test_flush();
    int stray = 0;
    for (int k = 0; k < 10; k++) begin
      idle();
      if (k < 3) set_req(0, $urandom, $urandom, TAGW'(k + 10));
      if (k == 2) bus.flush = 1'b1;
      sample();
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL flush cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
      checks++;
      if (k == 2) begin
        if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL flush_ready got %b exp 00", bus.req_ready); end
        checks++;
      end
      if (k == 3) begin
        if (bus.inflight !== '0) begin errors++; $display("FAIL flush_inflight got %0d exp 0", bus.inflight); end
        checks++;
      end
      if (bus.rsp_valid !== 2'b00) stray++;
      next();
    end
    if (stray != 0) begin errors++; $display("FAIL flush_stray got %0d responses exp 0", stray); end
    checks++;
    // Flush landing exactly on the cycle a result emerges.
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k == 0) set_req(1, $urandom, $urandom, 5'd9);
      if (k == 4) bus.flush = 1'b1;
      sample();
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL flush_emerge cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
      checks++;
      if (k == 4) begin
        if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL flush_emerge_rv got %b exp 00", bus.rsp_valid); end
        checks++;
      end
      next();
    end
  endtask

  task automatic test_ovf();
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k == 0) set_req(0, 32'h3F800000 | ($urandom & 32'h007FFFFF), 32'h0, 5'd17);
      sample();
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL ovf cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
      checks++;
      if (k == 4) begin
        if ({bus.rsp_valid, bus.rsp_ovf, bus.rsp_y} !== {2'b01, 1'b1, 32'h7F800000}) begin
          errors++; $display("FAIL ovf_pass got rv=%b ovf=%b y=%h exp rv=01 ovf=1 y=7f800000", bus.rsp_valid, bus.rsp_ovf, bus.rsp_y);
        end
        checks++;
      end
      next();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      idle();
      if (k < 290) begin
        for (int i = 0; i < NREQ; i++) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, TAGW'($urandom));
        end
        bus.flush = ($urandom_range(0, 15) == 0);
      end
      sample();
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
      checks++;
      next();
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k == 0) set_req(0, $urandom, $urandom, 5'd21);
      if (k == 1) set_req(1, $urandom, $urandom, 5'd22);
      sample();
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL async_pre cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
      checks++;
      next();
    end
    idle();
    #1;
    if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL async_emerge got %b exp 01", bus.rsp_valid); end
    checks++;
    rstn = 1'b0;
    #1;
    if ({bus.rsp_valid, bus.busy, bus.inflight} !== '0) begin
      errors++; $display("FAIL async_clear got rv=%b busy=%b inf=%0d exp 0", bus.rsp_valid, bus.busy, bus.inflight);
    end
    checks++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    m_ptr = NREQ - 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 7; k++) begin
      idle();
      if (k == 0) begin
        set_req(0, $urandom, $urandom, 5'd23);
        set_req(1, $urandom, $urandom, 5'd24);
      end
      sample();
      if (obs_vec() !== exp_vec) begin errors++; $display("FAIL async_post cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec); end
      checks++;
      if (k == 0) begin
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL async_first_grant got %b exp 01", bus.req_ready); end
        checks++;
      end
      next();
    end
  endtask

  initial begin
    idle();
    do_reset();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_ovf();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
